// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and the RAM model's status encoding.
package cpu_types_pkg;
  parameter int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

// File: rtl/mem_responder_pkg.sv
// Types and constants for the memory responder (state encoding, latched request, timeout load word).
package mem_responder_pkg;
  import cpu_types_pkg::*;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DREQ  = 3'd1,
    IREQ  = 3'd2,
    RETRY = 3'd3,
    DHIT  = 3'd4,
    IHIT  = 3'd5
  } resp_state_t;

  localparam word_t BAD_WORD = 32'hBAD1BAD1;

  typedef struct packed {
    logic  data;
    logic  wen;
    word_t addr;
    word_t store;
  } req_t;
endpackage

// File: rtl/mem_resp_watchdog.sv
// Saturating cycle counter for the responder; flags the cycle in which the limit is reached.
module mem_resp_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clr,
  input  logic inc,
  output logic expire
);
  localparam int unsigned LIM = (TIMEOUT < 1) ? 1 : TIMEOUT;
  localparam int CW = $clog2(LIM + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                         cnt <= '0;
    else if (clr)                      cnt <= '0;
    else if (inc && cnt != CW'(LIM))   cnt <= cnt + 1'b1;
  end

  // The LIM-th waiting cycle is the one that gives up.
  assign expire = inc && (cnt >= CW'(LIM - 1));
endmodule

// File: rtl/mem_responder.sv
// Serializes instruction/data requests onto a single-ported RAM and returns hit pulses.
// Optional watchdog enabled by defining MEM_RESP_TIMEOUT_EN.
module mem_responder
  import cpu_types_pkg::*;
  import mem_responder_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      imemREN,
  input  word_t     imemaddr,
  input  logic      dmemREN,
  input  logic      dmemWEN,
  input  word_t     dmemaddr,
  input  word_t     dmemstore,
  output logic      ihit,
  output logic      dhit,
  output word_t     imemload,
  output word_t     dmemload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      memerr
);
  resp_state_t state, nstate;
  req_t        req;
  logic        in_req, access, done, wd_expire;
  word_t       ld_word;

  assign in_req  = (state == DREQ) || (state == IREQ);
  assign access  = in_req && (ramstate == ACCESS);
  assign done    = access || wd_expire;
  assign ld_word = access ? ramload : BAD_WORD;

  always_comb begin
    nstate = state;
    case (state)
      IDLE: begin
        if (dmemWEN || dmemREN) nstate = DREQ;
        else if (imemREN)       nstate = IREQ;
      end
      DREQ, IREQ: begin
        if (done)                     nstate = req.data ? DHIT : IHIT;
        else if (ramstate == ERROR)   nstate = RETRY;
      end
      RETRY: begin
        if (wd_expire) nstate = req.data ? DHIT : IHIT;
        else           nstate = req.data ? DREQ : IREQ;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      req      <= '0;
      imemload <= '0;
      dmemload <= '0;
    end else begin
      state <= nstate;
      if (state == IDLE) begin
        // Data side wins; the latched copy is immune to later input changes.
        if (dmemWEN || dmemREN)
          req <= '{data: 1'b1, wen: dmemWEN, addr: dmemaddr, store: dmemstore};
        else if (imemREN)
          req <= '{data: 1'b0, wen: 1'b0, addr: imemaddr, store: '0};
      end
      if (done && !req.wen) begin
        if (req.data) dmemload <= ld_word;
        else          imemload <= ld_word;
      end
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (in_req) begin
      ramREN   = !req.wen;
      ramWEN   = req.wen;
      ramaddr  = req.addr;
      ramstore = req.store;
    end
  end

  assign ihit = (state == IHIT);
  assign dhit = (state == DHIT);

`ifdef MEM_RESP_TIMEOUT_EN
  logic wd_clr, wd_inc, memerr_q;

  // Count every non-ACCESS cycle of a request, RETRY included; restart from IDLE.
  assign wd_clr = (state == IDLE);
  assign wd_inc = (in_req && ramstate != ACCESS) || (state == RETRY);

  mem_resp_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .CLK    (CLK),
    .nRST   (nRST),
    .clr    (wd_clr),
    .inc    (wd_inc),
    .expire (wd_expire)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) memerr_q <= 1'b0;
    else       memerr_q <= wd_expire;
  end

  assign memerr = memerr_q;
`else
  logic unused_timeout;

  // Keeps the limit referenced when the watchdog is compiled out.
  assign unused_timeout = |TIMEOUT;
  assign wd_expire      = 1'b0;
  assign memerr         = 1'b0;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: scripted RAM agent plus latency/data reference model.
module tb_mem_responder;
  import cpu_types_pkg::*;

  localparam int unsigned TMO = 8;

  logic      CLK = 1'b0, nRST = 1'b0;
  logic      imemREN = 1'b0, dmemREN = 1'b0, dmemWEN = 1'b0;
  word_t     imemaddr = '0, dmemaddr = '0, dmemstore = '0;
  logic      ihit, dhit, ramREN, ramWEN, memerr;
  word_t     imemload, dmemload, ramaddr, ramstore, ramload;
  ramstate_t ramstate = FREE;

  int checks = 0, errors = 0;

  word_t     ram_mem [64];
  word_t     ref_mem [64];
  ramstate_t script[$];
  ramstate_t dflt_st = ACCESS;
  word_t     exp_addr = '0;
  logic      exp_wen = 1'b0;
  int        n_en = 0, n_bad = 0, n_acc = 0;

  mem_responder #(.TIMEOUT(TMO)) dut (
    .CLK(CLK), .nRST(nRST),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .ihit(ihit), .dhit(dhit), .imemload(imemload), .dmemload(dmemload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
  );

  always #5 CLK = ~CLK;

  assign ramload = ram_mem[ramaddr[7:2]];

  // RAM agent: status for each enabled cycle comes from the script, then the default.
  always @(negedge CLK) begin
    if (ramREN || ramWEN) begin
      n_en++;
      if (ramaddr !== exp_addr || ramWEN !== exp_wen || ramREN !== !exp_wen) n_bad++;
      if (script.size() > 0) ramstate = script.pop_front();
      else                   ramstate = dflt_st;
      if (ramstate == ACCESS) n_acc++;
    end else begin
      ramstate = FREE;
    end
  end

  always @(posedge CLK) begin
    if (ramWEN && ramstate == ACCESS) ram_mem[ramaddr[7:2]] = ramstore;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drop_reqs();
    imemREN   = 1'b0;
    dmemREN   = 1'b0;
    dmemWEN   = 1'b0;
    imemaddr  = $urandom;
    dmemaddr  = $urandom;
    dmemstore = $urandom;
  endtask

  // kind: 0 I-read, 1 D-read, 2 D-write, 3 D-write with REN also high (write wins).
  task automatic run_req(input int kind, input int idx, input word_t wd,
                         input int nfb, input int nerr, input bit hold);
    bit    isd = (kind != 0);
    bit    isw = (kind >= 2);
    word_t a = word_t'(idx) << 2;
    int    exp_lat = 2 + nfb + 2 * nerr;
    int    lat = 0, dh = 0, ih = 0, ec = 0;
    word_t old_d, old_i, lv = '0;
    @(negedge CLK);
    script.delete();
    for (int i = 0; i < nfb; i++) script.push_back(($urandom_range(0, 1) != 0) ? BUSY : FREE);
    for (int i = 0; i < nerr; i++) script.push_back(ERROR);
    script.shuffle();
    script.push_back(ACCESS);
    dflt_st = ACCESS; exp_addr = a; exp_wen = isw;
    n_en = 0; n_bad = 0; n_acc = 0;
    old_d = dmemload; old_i = imemload;
    if (isd) begin
      dmemREN = (kind != 2); dmemWEN = isw; dmemaddr = a; dmemstore = wd;
    end else begin
      imemREN = 1'b1; imemaddr = a;
    end
    if (isw) ref_mem[idx] = wd;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (k == 1 && !hold) drop_reqs();
      if (dhit) dh++;
      if (ihit) ih++;
      if (memerr) ec++;
      if ((dhit || ihit) && lat == 0) begin
        lat = k;
        lv  = isd ? dmemload : imemload;
        if (hold) drop_reqs();
      end
      if (lat != 0 && k >= lat + 3) break;
    end
    chk("latency", lat, exp_lat);
    chk("dhit_count", dh, {31'd0, isd});
    chk("ihit_count", ih, {31'd0, !isd});
    chk("memerr_count", ec, 0);
    chk("ram_enable_cycles", n_en, nfb + nerr + 1);
    chk("ram_drive_errors", n_bad, 0);
    chk("ram_access_count", n_acc, 1);
    if (isw) begin
      chk("dmemload_on_write", lv, old_d);
      chk("ram_written", ram_mem[idx], wd);
    end else begin
      chk("load_data", lv, ref_mem[idx]);
    end
    if (isd) chk("imemload_kept", imemload, old_i);
    else     chk("dmemload_kept", dmemload, old_d);
  endtask

  task automatic run_b2b();
    int    di = 20, ii = 21;
    word_t wd = $urandom;
    int    dl = 0, il = 0, dh = 0, ih = 0;
    word_t old_d, lv = '0;
    @(negedge CLK);
    script.delete();
    repeat (2) begin
      repeat (3) script.push_back(BUSY);
      script.push_back(ACCESS);
    end
    dflt_st = ACCESS; exp_addr = word_t'(di) << 2; exp_wen = 1'b1;
    n_en = 0; n_bad = 0; n_acc = 0;
    old_d = dmemload;
    dmemWEN = 1'b1; dmemaddr = word_t'(di) << 2; dmemstore = wd;
    imemREN = 1'b1; imemaddr = word_t'(ii) << 2;
    ref_mem[di] = wd;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (dhit) begin
        dh++;
        if (dl == 0) begin
          dl = k; dmemWEN = 1'b0; exp_addr = word_t'(ii) << 2; exp_wen = 1'b0;
        end
      end
      if (ihit) begin
        ih++;
        if (il == 0) begin il = k; imemREN = 1'b0; lv = imemload; end
      end
      if (il != 0 && k >= il + 3) break;
    end
    chk("b2b_dhit_latency", dl, 5);
    chk("b2b_ihit_latency", il, 11);
    chk("b2b_dhit_count", dh, 1);
    chk("b2b_ihit_count", ih, 1);
    chk("b2b_dmemload_kept", dmemload, old_d);
    chk("b2b_imemload", lv, ref_mem[ii]);
    chk("b2b_ram_written", ram_mem[di], wd);
    chk("b2b_ram_drive_errors", n_bad, 0);
    chk("b2b_ram_access_count", n_acc, 2);
    chk("b2b_ram_enable_cycles", n_en, 8);
  endtask

  task automatic run_reset_mid();
    @(negedge CLK);
    script.delete(); dflt_st = BUSY;
    exp_addr = word_t'(4) << 2; exp_wen = 1'b0;
    dmemREN = 1'b1; dmemaddr = word_t'(4) << 2;
    @(negedge CLK);
    drop_reqs();
    @(negedge CLK);
    chk("pre_reset_ramREN", ramREN, 1);
    @(posedge CLK);
    #2 nRST = 1'b0;
    #1;
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_hits", {30'd0, ihit, dhit}, 0);
    chk("rst_memerr", memerr, 0);
    chk("rst_imemload", imemload, 0);
    chk("rst_dmemload", dmemload, 0);
    @(negedge CLK);
    dflt_st = ACCESS;
    nRST = 1'b1;
  endtask

  task automatic run_timeout();
    int    idx = 33;
    int    lat = 0, ih = 0, eh = 0;
    word_t lv = '0;
    @(negedge CLK);
    script.delete(); dflt_st = BUSY;
    exp_addr = word_t'(idx) << 2; exp_wen = 1'b0;
    n_en = 0; n_bad = 0; n_acc = 0;
    imemREN = 1'b1; imemaddr = word_t'(idx) << 2;
`ifdef MEM_RESP_TIMEOUT_EN
    for (int k = 1; k <= 30; k++) begin
      @(negedge CLK);
      if (k == 1) drop_reqs();
      if (ihit) begin
        ih++;
        if (lat == 0) begin lat = k; eh = memerr; lv = imemload; end
      end
    end
    chk("timeout_latency", lat, TMO + 1);
    chk("timeout_memerr", eh, 1);
    chk("timeout_ihit_count", ih, 1);
    chk("timeout_imemload", lv, 32'hBAD1BAD1);
    chk("timeout_no_access", n_acc, 0);
`else
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (k == 1) drop_reqs();
      if (ihit || dhit) ih++;
      if (memerr) eh++;
    end
    chk("stuck_no_hit", ih, 0);
    chk("stuck_no_memerr", eh, 0);
    dflt_st = ACCESS;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      if (ihit && lat == 0) begin lat = k; lv = imemload; end
    end
    chk("release_latency", lat, 1);
    chk("release_imemload", lv, ref_mem[idx]);
`endif
    chk("timeout_ram_drive_errors", n_bad, 0);
    dflt_st = ACCESS;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit observed=expired expected=finish");
    $fatal(1, "time limit");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram_mem[i] = $urandom;
      ref_mem[i] = ram_mem[i];
    end
    #2;
    chk("reset_hits", {30'd0, ihit, dhit}, 0);
    chk("reset_ram_en", {30'd0, ramREN, ramWEN}, 0);
    chk("reset_ramaddr", ramaddr, 0);
    chk("reset_memerr", memerr, 0);
    chk("reset_imemload", imemload, 0);
    chk("reset_dmemload", dmemload, 0);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;

    ram_mem[16] = 32'hDEADBEEF; ref_mem[16] = 32'hDEADBEEF;
    run_req(1, 16, '0, 0, 0, 1'b1);
    run_req(1, 5, '0, 0, 1, 1'b1);
    run_req(0, 9, '0, 2, 0, 1'b0);
    run_req(3, 12, 32'h1234_5678, 1, 1, 1'b0);

    for (int t = 0; t < 24; t++)
      run_req($urandom_range(0, 3), $urandom_range(0, 63), $urandom,
              $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 1) != 0);

    run_b2b();
    run_reset_mid();
    run_req(1, 16, '0, 1, 0, 1'b1);
    run_timeout();
    run_req(0, 7, '0, 0, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
